// File: rtl/umi_sim_pkg.sv
// Shared UMI simulation definitions: packet width, destination field position and packet type.
package umi_sim_pkg;

    localparam int UMI_PKT_W    = 256;
    localparam int UMI_DEST_MSB = 255;
    localparam int UMI_DEST_LSB = 240;

    typedef logic [UMI_PKT_W-1:0] umi_pkt_t;

    function automatic logic [UMI_DEST_MSB-UMI_DEST_LSB:0] umi_dest(input umi_pkt_t pkt);
        return pkt[UMI_DEST_MSB:UMI_DEST_LSB];
    endfunction

endpackage

// File: rtl/umi_rr_arb.sv
// N-way grant logic for umi_tx_arb. With UMI_TX_ARB_RR_EN defined it owns the round-robin
// pointer; otherwise the lowest-index requester wins and no pointer is kept.
module umi_rr_arb #(
    parameter int N     = 2,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic [N-1:0]     req,
    input  logic             adv,
    output logic [N-1:0]     grant,
    output logic [PTR_W-1:0] winner
);

`ifdef UMI_TX_ARB_RR_EN
    logic [PTR_W-1:0] r_ptr;

    // Pointer moves one past the winner so the winner becomes lowest priority next time.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_ptr <= '0;
        end else if (adv) begin
            r_ptr <= (winner == PTR_W'(N-1)) ? '0 : winner + 1'b1;
        end
    end

    always_comb begin
        int   w_idx;
        logic w_found;
        grant   = '0;
        winner  = '0;
        w_found = 1'b0;
        for (int k = 0; k < N; k++) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= N) w_idx = w_idx - N;
            if (!w_found && req[w_idx]) begin
                w_found       = 1'b1;
                grant[w_idx]  = 1'b1;
                winner        = PTR_W'(w_idx);
            end
        end
    end
`else
    logic w_unused;
    assign w_unused = &{1'b0, clk, nreset, adv};

    always_comb begin
        logic w_found;
        grant   = '0;
        winner  = '0;
        w_found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!w_found && req[k]) begin
                w_found  = 1'b1;
                grant[k] = 1'b1;
                winner   = PTR_W'(k);
            end
        end
    end
`endif

endmodule

// File: rtl/umi_tx_arb.sv
// Merges N UMI packet streams into one registered output stage for umi_tx_sim.
// Define UMI_TX_ARB_RR_EN for round-robin arbitration; default is fixed lowest-index priority.
module umi_tx_arb
    import umi_sim_pkg::*;
#(
    parameter int N  = 2,
    parameter int PW = UMI_PKT_W
) (
    input  logic            clk,
    input  logic            nreset,
    input  logic [N*PW-1:0] in_packet,
    input  logic [N-1:0]    in_valid,
    output logic [N-1:0]    in_ready,
    output logic [PW-1:0]   out_packet,
    output logic            out_valid,
    input  logic            out_ready
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic             w_load;
    logic             w_any;
    logic             w_accept;
    logic [N-1:0]     w_grant;
    logic [PTR_W-1:0] w_winner;
    logic [PW-1:0]    w_win_pkt;
    logic [PW-1:0]    r_out_packet;
    logic             r_out_valid;

    // Output stage can take a packet when empty or being drained this same cycle.
    assign w_load   = !r_out_valid || out_ready;
    assign w_any    = |in_valid;
    assign w_accept = nreset && w_load && w_any;

    umi_rr_arb #(
        .N     (N),
        .PTR_W (PTR_W)
    ) u_arb (
        .clk    (clk),
        .nreset (nreset),
        .req    (in_valid),
        .adv    (w_accept),
        .grant  (w_grant),
        .winner (w_winner)
    );

    assign w_win_pkt = in_packet[w_winner*PW +: PW];
    assign in_ready  = (nreset && w_load) ? w_grant : '0;

    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_out_valid  <= 1'b0;
            r_out_packet <= '0;
        end else if (w_load) begin
            r_out_valid <= w_any;
            if (w_any) r_out_packet <= w_win_pkt;
        end
    end

    assign out_packet = r_out_packet;
    assign out_valid  = r_out_valid;

endmodule

// File: tb/tb_umi_tx_arb.sv
// Randomized bench for umi_tx_arb (N=3) against a transaction-level arbitration model.
module tb_umi_tx_arb;
    import umi_sim_pkg::*;

    localparam int N  = 3;
    localparam int PW = UMI_PKT_W;

    logic            clk = 1'b0;
    logic            nreset;
    logic [N*PW-1:0] in_packet;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_ready;
    logic [PW-1:0]   out_packet;
    logic            out_valid;
    logic            out_ready;

    always #5 clk = ~clk;

    umi_tx_arb #(.N(N), .PW(PW)) dut (
        .clk        (clk),
        .nreset     (nreset),
        .in_packet  (in_packet),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_packet (out_packet),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    logic [PW-1:0] pkt [N];
    logic [N-1:0]  vld;
    logic [PW-1:0] src [N][$];

    always_comb begin
        in_packet = '0;
        for (int i = 0; i < N; i++) in_packet[i*PW +: PW] = pkt[i];
    end
    assign in_valid = vld;

    // Model of the output stage and arbitration state.
    logic          m_full;
    logic [PW-1:0] m_pkt;
    int            m_ptr;
    int            glog[$];
    int            waitc[N];
    int            n_checks = 0;
    int            n_errors = 0;

    task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    function automatic int exp_winner(input logic [N-1:0] v, input int p);
`ifdef UMI_TX_ARB_RR_EN
        for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
`else
        for (int k = 0; k < N; k++) if (v[k] && p >= 0) return k;
`endif
        return -1;
    endfunction

    function automatic logic [PW-1:0] rpkt();
        logic [PW-1:0] p;
        for (int k = 0; k < PW/32; k++) p[k*32 +: 32] = $urandom;
        return p;
    endfunction

    function automatic bit busy();
        bit b = m_full || (vld != '0);
        for (int i = 0; i < N; i++) if (src[i].size() != 0) b = 1'b1;
        return b;
    endfunction

    // Hold valid once raised until the model sees the packet accepted.
    task automatic drive(input int pct);
        for (int i = 0; i < N; i++) begin
            if (!vld[i] && src[i].size() != 0 && $urandom_range(99) < pct) begin
                vld[i] = 1'b1;
                pkt[i] = src[i][0];
            end
        end
    endtask

    // Called at a falling edge; checks outputs, advances one clock, updates the model.
    task automatic step();
        int            w;
        logic          ld;
        logic [N-1:0]  er;
        #1;
        ld = !m_full || out_ready;
        w  = exp_winner(vld, m_ptr);
        er = '0;
        if (nreset && ld && w >= 0) er[w] = 1'b1;
        chk("in_ready", 256'(in_ready), 256'(er));
        if (nreset) begin
            chk("out_valid", 256'(out_valid), 256'(m_full));
            if (m_full) begin
                chk("out_packet", out_packet, m_pkt);
                chk("dest", 256'(out_packet[UMI_DEST_MSB:UMI_DEST_LSB]),
                    256'(m_pkt[UMI_DEST_MSB:UMI_DEST_LSB]));
            end
        end
        @(posedge clk);
        #1;
        if (!nreset) begin
            m_full = 1'b0;
            m_pkt  = '0;
            m_ptr  = 0;
            for (int i = 0; i < N; i++) waitc[i] = 0;
        end else if (ld) begin
            if (w >= 0) begin
`ifdef UMI_TX_ARB_RR_EN
                for (int i = 0; i < N; i++) if (i != w && vld[i]) waitc[i]++;
                chk("fair", 256'(waitc[w] <= N - 1), 256'(1));
                waitc[w] = 0;
`endif
                m_full = 1'b1;
                m_pkt  = pkt[w];
                m_ptr  = (w + 1) % N;
                glog.push_back(w);
                void'(src[w].pop_front());
                vld[w] = 1'b0;
            end else begin
                m_full = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic run_idle(input int pct, input int maxc);
        int c = 0;
        out_ready = 1'b1;
        while (busy() && c < maxc) begin
            drive(pct);
            step();
            c++;
        end
        if (c >= maxc) chk("timeout", 256'(1), 256'(0));
    endtask

    task automatic do_reset();
        nreset = 1'b0;
        step();
        nreset = 1'b1;
        chk("rst_valid", 256'(out_valid), 256'(0));
        chk("rst_pkt", out_packet, 256'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int            exp_ord[$];
        int            c;
        logic [PW-1:0] p;
        nreset    = 1'b0;
        out_ready = 1'b1;
        vld       = '0;
        for (int i = 0; i < N; i++) begin pkt[i] = '0; waitc[i] = 0; end
        m_full = 1'b0;
        m_pkt  = '0;
        m_ptr  = 0;
        @(negedge clk);
        do_reset();

        // Single packet on port 0.
        p = {4'hA, 248'h0, 4'h1};
        src[0].push_back(p);
        run_idle(100, 20);

        // Contention with all candidates continuously valid.
        do_reset();
        glog.delete();
`ifdef UMI_TX_ARB_RR_EN
        for (int r = 0; r < 3; r++) for (int i = 0; i < N; i++) src[i].push_back(rpkt());
        exp_ord = '{0, 1, 2, 0, 1, 2, 0, 1, 2};
`else
        for (int r = 0; r < 5; r++) src[0].push_back(rpkt());
        for (int r = 0; r < 2; r++) src[1].push_back(rpkt());
        exp_ord = '{0, 0, 0, 0, 0, 1, 1};
`endif
        run_idle(100, 40);
        chk("grant_cnt", 256'(glog.size()), 256'(exp_ord.size()));
        for (int k = 0; k < exp_ord.size() && k < glog.size(); k++)
            chk("grant_order", 256'(glog[k]), 256'(exp_ord[k]));

        // Backpressure for 4 cycles with a full output stage.
        for (int r = 0; r < 2; r++) begin src[0].push_back(rpkt()); src[2].push_back(rpkt()); end
        out_ready = 1'b1;
        drive(100);
        step();
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin drive(100); step(); end
        run_idle(100, 40);

        // Reset while a packet for dest 0x0042 is held.
        p = rpkt();
        p[UMI_DEST_MSB:UMI_DEST_LSB] = 16'h0042;
        src[1].push_back(p);
        out_ready = 1'b0;
        c = 0;
        while (!m_full && c < 10) begin drive(100); step(); c++; end
        chk("mid_loaded", 256'(m_full), 256'(1));
        step();
        nreset = 1'b0;
        step();
        nreset = 1'b1;
        chk("mid_rst_valid", 256'(out_valid), 256'(0));
        chk("mid_rst_pkt", out_packet, 256'(0));
        run_idle(100, 20);

        // Destination passthrough.
        p = rpkt();
        p[UMI_DEST_MSB:UMI_DEST_LSB] = 16'hBEEF;
        src[2].push_back(p);
        run_idle(100, 20);
        chk("beef_dest", 256'(m_pkt[UMI_DEST_MSB:UMI_DEST_LSB]), 256'(16'hBEEF));

        // Random traffic, backpressure and occasional resets.
        for (int cyc = 0; cyc < 800; cyc++) begin
            for (int i = 0; i < N; i++)
                if (src[i].size() < 4 && $urandom_range(99) < 30) src[i].push_back(rpkt());
            out_ready = ($urandom_range(99) < 70);
            nreset    = ($urandom_range(199) != 0);
            drive($urandom_range(100, 40));
            step();
        end
        nreset = 1'b1;
        run_idle(100, 200);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
